// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit for the 16-bit, 8-register datapath: captures a 9-bit
// instruction from Din and sequences T0..T3, driving one-hot bus selects and enables.
module proc_control_fsm #(
  parameter int DATA_W = 16,
  parameter int IR_LSB = 0
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Run,
  input  logic [DATA_W-1:0] Din,
  input  logic              G_nz,
  output logic [7:0]        R_out,
  output logic              G_out,
  output logic              DIN_out,
  output logic [7:0]        R_in,
  output logic              A_in,
  output logic              G_in,
  output logic              AddSub,
  output logic              Done,
  output logic              Busy
);

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;

  tstep_t     tstep;
  logic [8:0] ir;
  logic [2:0] op;
  logic [7:0] x_sel;
  logic [7:0] y_sel;

  assign op    = ir[8:6];
  assign x_sel = 8'h01 << ir[5:3];
  assign y_sel = 8'h01 << ir[2:0];
  assign Busy  = (tstep != T0);

  // Done always returns to T0, so T3 (which always has Done) never wraps.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep <= T0;
      ir    <= 9'd0;
    end else begin
      case (tstep)
        T0: begin
          if (Run) begin
            ir    <= Din[IR_LSB +: 9];
            tstep <= T1;
          end
        end
        T1:      tstep <= Done ? T0 : T2;
        T2:      tstep <= T3;
        default: tstep <= T0;
      endcase
    end
  end

  // Each select is a single decoded bit per step, which keeps the bus at most one-hot.
  always_comb begin
    R_out   = 8'h00;
    G_out   = 1'b0;
    DIN_out = 1'b0;
    R_in    = 8'h00;
    A_in    = 1'b0;
    G_in    = 1'b0;
    AddSub  = 1'b0;
    Done    = 1'b0;
    case (tstep)
      T1: begin
        case (op)
          OP_MV: begin
            R_out = y_sel;
            R_in  = x_sel;
            Done  = 1'b1;
          end
          OP_MVI: begin
            DIN_out = 1'b1;
            R_in    = x_sel;
            Done    = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            R_out = x_sel;
            A_in  = 1'b1;
          end
          OP_MVNZ: begin
            R_out = y_sel;
            R_in  = G_nz ? x_sel : 8'h00;
            Done  = 1'b1;
          end
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        if (op == OP_ADD || op == OP_SUB) begin
          R_out  = y_sel;
          G_in   = 1'b1;
          AddSub = (op == OP_SUB);
        end
      end
      T3: begin
        G_out = 1'b1;
        R_in  = x_sel;
        Done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Scoreboard bench for proc_control_fsm: stimulus pushes expected per-step outputs,
// a negedge monitor pops and compares them whenever the DUT is busy.
module tb_proc_control_fsm;

  localparam int DATA_W = 16;

  logic              clock = 1'b0;
  logic              resetn;
  logic              run;
  logic [DATA_W-1:0] din;
  logic              g_nz;
  logic [7:0]        r_out;
  logic              g_out;
  logic              din_out;
  logic [7:0]        r_in;
  logic              a_in;
  logic              g_in;
  logic              add_sub;
  logic              done;
  logic              busy;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [22:0] exp_q[$];
  logic [22:0] dut_vec;

  proc_control_fsm #(.DATA_W(DATA_W), .IR_LSB(0)) dut (
    .Clock   (clock),
    .Resetn  (resetn),
    .Run     (run),
    .Din     (din),
    .G_nz    (g_nz),
    .R_out   (r_out),
    .G_out   (g_out),
    .DIN_out (din_out),
    .R_in    (r_in),
    .A_in    (a_in),
    .G_in    (g_in),
    .AddSub  (add_sub),
    .Done    (done),
    .Busy    (busy)
  );

  always #5 clock = ~clock;

  assign dut_vec = {r_out, g_out, din_out, r_in, a_in, g_in, add_sub, done, busy};

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected busy-cycle vector: fields in the same order as dut_vec, Busy=1.
  function automatic logic [22:0] vec(input logic [7:0] ro, input logic go, input logic dio,
                                      input logic [7:0] ri, input logic ai, input logic gi,
                                      input logic as, input logic dn);
    return {ro, go, dio, ri, ai, gi, as, dn, 1'b1};
  endfunction

  function automatic logic [22:0] model_vec(input logic [2:0] op, input logic [2:0] x,
                                            input logic [2:0] y, input int step, input logic gnz);
    logic [7:0] xs;
    logic [7:0] ys;
    xs = 8'h01 << x;
    ys = 8'h01 << y;
    case (op)
      3'b000: return vec(ys, 0, 0, xs, 0, 0, 0, 1);
      3'b001: return vec(8'h00, 0, 1, xs, 0, 0, 0, 1);
      3'b010, 3'b011: begin
        if (step == 1) return vec(xs, 0, 0, 8'h00, 1, 0, 0, 0);
        if (step == 2) return vec(ys, 0, 0, 8'h00, 0, 1, op[0], 0);
        return vec(8'h00, 1, 0, xs, 0, 0, 0, 1);
      end
      3'b100: return vec(ys, 0, 0, gnz ? xs : 8'h00, 0, 0, 0, 1);
      default: return vec(8'h00, 0, 0, 8'h00, 0, 0, 0, 1);
    endcase
  endfunction

  always @(negedge clock) begin
    logic [22:0] exp_v;
    check_output("bus_onehot", {31'd0, $onehot0({r_out, g_out, din_out})}, 32'd1);
    check_output("rin_onehot", {31'd0, $onehot0(r_in)}, 32'd1);
    if (busy) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_busy", {9'd0, dut_vec}, 32'd0);
      end else begin
        exp_v = exp_q.pop_front();
        check_output("step_outputs", {9'd0, dut_vec}, {9'd0, exp_v});
      end
    end else begin
      check_output("t0_idle", {9'd0, dut_vec}, 32'd0);
    end
  end

  // Issue one instruction from T0; leaves the bench at T0 after n_steps busy cycles.
  task automatic apply_stimulus(input logic [8:0] instr, input logic gnz, input int n_steps,
                                input logic hold_run, input logic [DATA_W-1:0] next_din);
    run  = 1'b1;
    din  = {7'h55, instr};
    g_nz = gnz;
    @(posedge clock); #1;
    check_output("start_busy", {31'd0, busy}, 32'd1);
    run = hold_run;
    din = next_din;
    repeat (n_steps) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic random_issue(input logic [8:0] instr, input logic gnz, input int n_steps);
    run  = 1'b1;
    din  = {7'($urandom), instr};
    g_nz = gnz;
    @(posedge clock); #1;
    check_output("start_busy_rand", {31'd0, busy}, 32'd1);
    repeat (n_steps) begin
      run = 1'($urandom);
      din = 16'($urandom);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    resetn = 1'b0;
    run    = 1'b0;
    din    = '0;
    g_nz   = 1'b0;
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;
    @(posedge clock); #1;

    // mvi R2
    exp_q.push_back(vec(8'h00, 0, 1, 8'h04, 0, 0, 0, 1));
    apply_stimulus(9'b001_010_000, 1'b0, 1, 1'b0, 16'h0abc);
    @(posedge clock); #1;

    // add R1,R5
    exp_q.push_back(vec(8'h02, 0, 0, 8'h00, 1, 0, 0, 0));
    exp_q.push_back(vec(8'h20, 0, 0, 8'h00, 0, 1, 0, 0));
    exp_q.push_back(vec(8'h00, 1, 0, 8'h02, 0, 0, 0, 1));
    apply_stimulus(9'b010_001_101, 1'b0, 3, 1'b0, 16'hffff);

    // sub R7,R0 then mv R0,R7 back to back with Run held high
    exp_q.push_back(vec(8'h80, 0, 0, 8'h00, 1, 0, 0, 0));
    exp_q.push_back(vec(8'h01, 0, 0, 8'h00, 0, 1, 1, 0));
    exp_q.push_back(vec(8'h00, 1, 0, 8'h80, 0, 0, 0, 1));
    apply_stimulus(9'b011_111_000, 1'b0, 3, 1'b1, {7'h55, 9'b000_000_111});
    exp_q.push_back(vec(8'h80, 0, 0, 8'h01, 0, 0, 0, 1));
    apply_stimulus(9'b000_000_111, 1'b0, 1, 1'b0, 16'h0000);

    // mvnz R4,R6 with G_nz low then high
    exp_q.push_back(vec(8'h40, 0, 0, 8'h00, 0, 0, 0, 1));
    apply_stimulus(9'b100_100_110, 1'b0, 1, 1'b0, 16'h0000);
    exp_q.push_back(vec(8'h40, 0, 0, 8'h10, 0, 0, 0, 1));
    apply_stimulus(9'b100_100_110, 1'b1, 1, 1'b0, 16'h0000);

    // mv R3,R3 and two nops
    exp_q.push_back(vec(8'h08, 0, 0, 8'h08, 0, 0, 0, 1));
    apply_stimulus(9'b000_011_011, 1'b0, 1, 1'b0, 16'h0000);
    exp_q.push_back(vec(8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    apply_stimulus(9'b101_010_001, 1'b1, 1, 1'b0, 16'h0000);
    exp_q.push_back(vec(8'h00, 0, 0, 8'h00, 0, 0, 0, 1));
    apply_stimulus(9'b111_111_111, 1'b0, 1, 1'b0, 16'h0000);

    // reset asserted in T2 of add R1,R5
    exp_q.push_back(vec(8'h02, 0, 0, 8'h00, 1, 0, 0, 0));
    exp_q.push_back(vec(8'h20, 0, 0, 8'h00, 0, 1, 0, 0));
    run = 1'b1;
    din = {7'h00, 9'b010_001_101};
    @(posedge clock); #1;
    run = 1'b0;
    @(posedge clock);
    @(negedge clock); #2;
    resetn = 1'b0;
    #1;
    check_output("reset_async", {9'd0, dut_vec}, 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;
    check_output("reset_release_busy", {31'd0, busy}, 32'd0);

    // random instructions with random Run/Din noise while busy
    for (int i = 0; i < 2000; i++) begin
      logic [8:0] instr;
      logic       gnz;
      int         n;
      instr = 9'($urandom);
      gnz   = 1'($urandom);
      n     = (instr[8:6] == 3'b010 || instr[8:6] == 3'b011) ? 3 : 1;
      for (int s = 1; s <= n; s++)
        exp_q.push_back(model_vec(instr[8:6], instr[5:3], instr[2:0], s, gnz));
      random_issue(instr, gnz, n);
      if ($urandom_range(0, 3) == 0) begin
        run = 1'b0;
        @(posedge clock); #1;
      end
    end

    run = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_output("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
